pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32I core.
- Takes the load-use stall from the hazard/bypass unit, branch/jump redirect from E, and instruction- and data-memory ready handshakes.
- Drives per-register enables and flushes for PC, F/D, D/E, E/M and M/W.
- Also owns the post-reset pipeline fill, a data-memory wait timeout and saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/pipe_ctrl_sat_counter.sv | 23 ++
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding,
// the NOP instruction word and the layout of the enable/flush control vector.
package pipe_ctrl_defs;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Bit positions inside the control vector
    localparam int CTL_PC_EN    = 0;
    localparam int CTL_FD_EN    = 1;
    localparam int CTL_DE_EN    = 2;
    localparam int CTL_EM_EN    = 3;
    localparam int CTL_MW_EN    = 4;
    localparam int CTL_FD_FLUSH = 5;
    localparam int CTL_DE_FLUSH = 6;
    localparam int CTL_MW_FLUSH = 7;
    localparam int CTL_W        = 8;

    // Every register advances, nothing flushed
    localparam logic [CTL_W-1:0] CTL_ALL_EN    = 8'b0001_1111;
    // Data memory stalled: freeze everything, bubble into M/W
    localparam logic [CTL_W-1:0] CTL_MEM_STALL = 8'b1001_0000;
    // Post-reset fill: PC held, NOPs pushed through F/D, D/E, E/M, M/W
    localparam logic [CTL_W-1:0] CTL_RST_HOLD  = 8'b1110_1110;

    // Priority resolution once the data memory is not holding the pipe
    function automatic logic [CTL_W-1:0] run_ctl(input logic redirect,
                                                 input logic stall_load,
                                                 input logic imem_ready);
        logic [CTL_W-1:0] c;
        c = CTL_ALL_EN;
        if (redirect) begin
            // Wrong-path D and a missing fetch are both discarded; PC takes the target
            c[CTL_FD_FLUSH] = 1'b1;
            c[CTL_DE_FLUSH] = 1'b1;
        end else if (stall_load) begin
            c[CTL_PC_EN]    = 1'b0;
            c[CTL_FD_EN]    = 1'b0;
            c[CTL_DE_FLUSH] = 1'b1;
        end else if (!imem_ready) begin
            c[CTL_PC_EN]    = 1'b0;
            c[CTL_FD_FLUSH] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] count_q;

    // Count up on inc, stick at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (inc && (count_q != '1))
            count_q <= count_q + W'(1);
    end

    assign q = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: per-register
// enables/flushes, post-reset fill, data-memory wait with timeout flag and
// saturating stall/flush counters.
module pipe_ctrl
    import pipe_ctrl_defs::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_load,
    input  logic             redirect_E,
    input  logic             imem_ready,
    input  logic             dmem_req_M,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             mw_flush,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic              err_q, err_d;
    logic [CTL_W-1:0]  ctl;
    logic              mem_stall, mem_wait_cyc, stall_inc, flush_inc;

    assign mem_stall = dmem_req_M & ~dmem_ready;
    // wait_cnt counts every stalled memory cycle, including the entry cycle in RUN
    assign wait_inc  = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

    // State, hold/wait counters and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_HOLD;
            hold_cnt_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        mem_wait_cyc = 1'b0;
        case (state_q)
            RST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (mem_stall) begin
                    state_d      = MEM_WAIT;
                    wait_cnt_d   = wait_inc;
                    mem_wait_cyc = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d   = wait_inc;
                    mem_wait_cyc = 1'b1;
                end
            end
            default: state_d = RST_HOLD;
        endcase
        err_d = err_q | (mem_wait_cyc && (wait_inc == WAIT_MAX));
    end

    // Stage enables/flushes and counter increments
    always_comb begin
        ctl       = '0;
        flush_inc = 1'b0;
        case (state_q)
            RST_HOLD: ctl = CTL_RST_HOLD;
            RUN: begin
                if (mem_stall) begin
                    ctl = CTL_MEM_STALL;
                end else begin
                    ctl       = run_ctl(redirect_E, stall_load, imem_ready);
                    flush_inc = redirect_E;
                end
            end
            MEM_WAIT: begin
                // E is frozen during the wait, so a pending redirect is acted on once here
                if (dmem_ready) begin
                    ctl       = run_ctl(redirect_E, stall_load, imem_ready);
                    flush_inc = redirect_E;
                end else begin
                    ctl = CTL_MEM_STALL;
                end
            end
            default: ctl = CTL_RST_HOLD;
        endcase
        stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && !ctl[CTL_PC_EN];
    end

    assign pc_en       = ctl[CTL_PC_EN];
    assign fd_en       = ctl[CTL_FD_EN];
    assign de_en       = ctl[CTL_DE_EN];
    assign em_en       = ctl[CTL_EM_EN];
    assign mw_en       = ctl[CTL_MW_EN];
    assign fd_flush    = ctl[CTL_FD_FLUSH];
    assign de_flush    = ctl[CTL_DE_FLUSH];
    assign mw_flush    = ctl[CTL_MW_FLUSH];
    assign err_timeout = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .q   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a vector table for the default instance plus
// hand sequences for timeout and counter saturation on a small instance.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst, stall_load, redirect_E, imem_ready, dmem_req_M, dmem_ready;

    logic        pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, mw_flush, err;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_en, s_fd_en, s_de_en, s_em_en, s_mw_en, s_fd_flush, s_de_flush, s_mw_flush, s_err;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    logic [7:0] ctl_act;
    assign ctl_act = {mw_flush, de_flush, fd_flush, mw_en, em_en, de_en, fd_en, pc_en};

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .stall_load(stall_load), .redirect_E(redirect_E),
        .imem_ready(imem_ready), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .mw_flush(mw_flush),
        .err_timeout(err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.RST_CYCLES(4), .MEM_TIMEOUT(3), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .stall_load(stall_load), .redirect_E(redirect_E),
        .imem_ready(imem_ready), .dmem_req_M(dmem_req_M), .dmem_ready(dmem_ready),
        .pc_en(s_pc_en), .fd_en(s_fd_en), .de_en(s_de_en), .em_en(s_em_en), .mw_en(s_mw_en),
        .fd_flush(s_fd_flush), .de_flush(s_de_flush), .mw_flush(s_mw_flush),
        .err_timeout(s_err), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // ctl bits: {mw_flush, de_flush, fd_flush, mw_en, em_en, de_en, fd_en, pc_en}
    localparam logic [7:0] C_HOLD = 8'hEE;
    localparam logic [7:0] C_IDLE = 8'h1F;
    localparam logic [7:0] C_LDU  = 8'h5C;
    localparam logic [7:0] C_RDR  = 8'h7F;
    localparam logic [7:0] C_IMW  = 8'h3E;
    localparam logic [7:0] C_MEM  = 8'h90;

    typedef struct {
        logic       rst, sl, rd, im, dq, dr;
        logic       chk;
        logic [7:0] ctl;
        int         stall, flush;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic sl, logic rd, logic im, logic dq, logic dr,
                               logic chk, logic [7:0] ctl, int st, int fl);
        vec_t t;
        t.rst = r; t.sl = sl; t.rd = rd; t.im = im; t.dq = dq; t.dr = dr;
        t.chk = chk; t.ctl = ctl; t.stall = st; t.flush = fl;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic sl, input logic rd,
                         input logic im, input logic dq, input logic dr);
        @(negedge clk);
        rst = r; stall_load = sl; redirect_E = rd;
        imem_ready = im; dmem_req_M = dq; dmem_ready = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall_load = 1'b0; redirect_E = 1'b0;
        imem_ready = 1'b1; dmem_req_M = 1'b0; dmem_ready = 1'b0;

        //              rst sl rd im dq dr chk ctl     stall flush
        // reset then idle: 3 reset cycles, 4 hold cycles, then RUN
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, C_HOLD, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_IDLE, 0, 0));
        // load-use, redirect vs stall, fetch miss, redirect vs fetch miss
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 1, C_LDU,  1, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_IDLE, 1, 0));
        tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, C_RDR,  1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, C_IMW,  2, 1));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, C_RDR,  2, 2));
        // memory wait with redirect pending throughout: 5 stall cycles, release counts once
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, C_MEM,  3, 2));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, C_MEM,  4, 2));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, C_MEM,  5, 2));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, C_MEM,  6, 2));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, C_MEM,  7, 2));
        tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, C_RDR,  7, 3));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_IDLE, 7, 3));
        // release cycle resolving to a load-use stall
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, C_MEM,  8, 3));
        tbl.push_back(v(0, 1, 0, 1, 1, 1, 1, C_LDU,  9, 3));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_IDLE, 9, 3));
        // reset in the middle of MEM_WAIT clears counters and restarts the hold
        tbl.push_back(v(0, 0, 0, 1, 1, 0, 1, C_MEM, 10, 3));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 1, C_MEM,  0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_HOLD, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, C_IDLE, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].sl, tbl[i].rd, tbl[i].im, tbl[i].dq, tbl[i].dr);
            if (tbl[i].chk)
                chk($sformatf("ctl[%0d]", i), {24'd0, ctl_act}, {24'd0, tbl[i].ctl});
            tick();
            chk($sformatf("stall_cnt[%0d]", i), stall_cnt, tbl[i].stall);
            chk($sformatf("flush_cnt[%0d]", i), flush_cnt, tbl[i].flush);
            chk($sformatf("err[%0d]", i), {31'd0, err}, 32'd0);
        end

        // timeout on the MEM_TIMEOUT=3 instance: flag visible from the 4th stalled cycle
        drive(1, 0, 0, 1, 0, 0); tick();
        repeat (4) begin drive(0, 0, 0, 1, 0, 0); tick(); end
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 1, 1, 0);
            chk($sformatf("err_to_c%0d", k), {31'd0, s_err}, {31'd0, (k >= 4)});
            tick();
        end
        chk("err_default_no_to", {31'd0, err}, 32'd0);
        chk("stall_default_wait", stall_cnt, 32'd6);
        drive(1, 0, 0, 1, 1, 0); tick();
        chk("err_to_after_rst", {31'd0, s_err}, 32'd0);
        repeat (4) begin drive(0, 0, 0, 1, 0, 0); tick(); end

        // saturation on the CNT_W=3 instance
        for (int k = 1; k <= 10; k++) begin
            drive(0, 1, 0, 1, 0, 0);
            tick();
            chk($sformatf("sat_stall_%0d", k), {29'd0, s_stall_cnt}, (k < 7) ? k : 7);
        end
        drive(0, 1, 0, 1, 0, 0); tick();
        chk("sat_stall_held", {29'd0, s_stall_cnt}, 32'd7);
        chk("wide_stall_nosat", stall_cnt, 32'd11);
        chk("sat_flush_zero", {29'd0, s_flush_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
